mod_hi_speed_protocol_decoder: RTL and testbench
================================================

// Module: mod_hi_speed_protocol_decoder
// PURPOSE
//  Receive-side counterpart of the hi-speed protocol coder. Consumes bytes from the RS byte
//  decoder and parses frames of the form MARKER, FLAG, LEN_H, LEN_L, DATA[LEN], CRC_H, CRC_L.
//  Writes DATA bytes to the RX RAM through a req/rdy port and checks CRC-16 over MARKER..DATA.
//  Reports the frame header, a completion pulse and error status to the host controller.
// PARAMETERS
//  QUARTZ       24      CLK frequency, MHz; used for the inter-byte timeout
//  MARKER_BYTE  8'hB6   frame start byte
//  TIMEOUT_US   200     max gap between bytes inside a frame, us
//  MAX_BYTES    4096    largest accepted LEN
// PORTS
//  CLK              in   1   system clock; all logic on posedge
//  RESET            in   1   asynchronous, active-high reset
//  RX_DATA          in   8   byte from RS decoder, valid while RX_STR=1
//  RX_STR           in   1   one-CLK strobe: RX_DATA valid
//  RX_ERR           in   1   parity/stop error on the byte strobed with RX_STR
//  RX_RAM_REQ_WR    out  1   RAM write request, held until RX_RAM_RDY_WR
//  RX_RAM_RDY_WR    in   1   write done; one-CLK pulse
//  RX_RAM_ADDR_OUT  out  16  RAM write address, 0..LEN-1
//  RX_RAM_DATA_OUT  out  8   RAM write data
//  DECODING         out  1   high from accepted MARKER until frame end/abort
//  RX_FLAG          out  8   FLAG of the last frame (updated when the FLAG byte arrives)
//  RX_BYTE_NUMBER   out  16  LEN of the last frame (updated when LEN_L arrives)
//  RX_DONE          out  1   one-CLK pulse: frame received completely (CRC good or bad)
//  RX_CRC_ERR       out  1   valid with RX_DONE: 1 = CRC mismatch
//  RX_ABORT         out  1   one-CLK pulse: frame abandoned (timeout/length/byte/overrun error)
// BEHAVIOUR
//  Reset: all outputs 0, address 0, FSM=IDLE, timeout counter 0, CRC cleared.
//  A byte is "accepted" on a CLK edge where RX_STR=1; RX_STR is ignored in the RAM write states.
//  FSM:
//   IDLE   : DECODING=0, CRC cleared. Accepted byte==MARKER_BYTE with RX_ERR=0 -> FLAG, DECODING<=1.
//            Any other byte is discarded silently.
//   FLAG   : byte -> RX_FLAG -> LEN_H.   LEN_H: byte -> len[15:8] -> LEN_L.
//   LEN_L  : byte -> len[7:0], RX_BYTE_NUMBER<={len_h,byte}; LEN==0 -> CRC_H;
//            LEN>MAX_BYTES -> abort; otherwise -> DATA with address 0.
//   DATA   : byte -> RX_RAM_DATA_OUT, REQ_WR<=1 -> WR.
//   WR     : hold REQ/ADDR/DATA; on RDY_WR: REQ<=0, ADDR+=1; when bytes written==LEN -> CRC_H,
//            otherwise -> DATA. RX_STR during WR -> abort (overrun).
//   CRC_H / CRC_L: byte -> rx_crc[15:8] / rx_crc[7:0]; after CRC_L -> CHECK.
//   CHECK  : one CLK: RX_DONE=1, RX_CRC_ERR=(rx_crc!=crc_calc); DECODING<=0 -> IDLE.
//  CRC: codebase crc16 instance (as used by the coder). clk_en = accepted byte in
//   MARKER..DATA states; clr = (FSM==IDLE) & ~marker-accept; reset port driven by ~RESET.
//   CRC bytes are not fed into it. The CRC_H byte is compared with data_out[15:8].
//  Timeout: counter clears on every accepted byte and in IDLE; counts CLK while DECODING=1
//   and FSM not in WR; at QUARTZ*TIMEOUT_US-1 -> abort.
//  Abort (any cause; RX_ERR=1 on an accepted byte outside IDLE also aborts): RX_ABORT pulse,
//   REQ_WR<=0, DECODING<=0, ADDR<=0 -> IDLE. No RX_DONE. RX_FLAG/RX_BYTE_NUMBER keep their values.
//  Simultaneous: the byte that causes CHECK does not start a new frame; the next frame requires
//   IDLE first. RX_DONE and RX_ABORT are never high together.
//  RESET mid-frame: immediate return to reset state; a pending RAM request drops asynchronously.
//  RX_RAM_ADDR_OUT 16-bit, no wrap: LEN<=MAX_BYTES guarantees ADDR<=MAX_BYTES-1.
// TESTING
//  1 Frame B6,05,00,03,11,22,33,crc(B6..33) with RDY 2 CLK after REQ -> RAM[0..2]=11,22,33,
//    RX_FLAG=05, RX_BYTE_NUMBER=3, RX_DONE pulse, RX_CRC_ERR=0, single pulse, DECODING low after.
//  2 Same frame with CRC_L xor 01 -> RAM written, RX_DONE=1 with RX_CRC_ERR=1.
//  3 Bytes 00,FF then B6,7A,00,00,crc -> leading bytes ignored; RX_DONE, LEN=0, no REQ_WR.
//  4 B6,01,00,02,AA then 250 us silence -> RX_ABORT within TIMEOUT_US, REQ_WR=0; next good frame
//    decodes normally with ADDR restarting at 0.
//  5 LEN=0x1001 (MAX_BYTES=4096) -> RX_ABORT on LEN_L; RX_ERR on FLAG byte -> RX_ABORT.
//  6 RESET high while REQ_WR=1 mid-data -> all outputs 0 at once; after release, frame 1 passes.

Source files
------------

// File: rtl/mod_hi_speed_protocol_decoder_if.sv
// Byte-stream input, RX RAM write port and frame status of the hi-speed protocol decoder.
// The decoder takes the slave modport; the byte source, RAM and host take the master side.
interface mod_hi_speed_protocol_decoder_if;
    logic [7:0]  RX_DATA;
    logic        RX_STR;
    logic        RX_ERR;
    logic        RX_RAM_REQ_WR;
    logic        RX_RAM_RDY_WR;
    logic [15:0] RX_RAM_ADDR_OUT;
    logic [7:0]  RX_RAM_DATA_OUT;
    logic        DECODING;
    logic [7:0]  RX_FLAG;
    logic [15:0] RX_BYTE_NUMBER;
    logic        RX_DONE;
    logic        RX_CRC_ERR;
    logic        RX_ABORT;

    modport slave (
        input  RX_DATA, RX_STR, RX_ERR, RX_RAM_RDY_WR,
        output RX_RAM_REQ_WR, RX_RAM_ADDR_OUT, RX_RAM_DATA_OUT, DECODING,
               RX_FLAG, RX_BYTE_NUMBER, RX_DONE, RX_CRC_ERR, RX_ABORT
    );

    modport master (
        output RX_DATA, RX_STR, RX_ERR, RX_RAM_RDY_WR,
        input  RX_RAM_REQ_WR, RX_RAM_ADDR_OUT, RX_RAM_DATA_OUT, DECODING,
               RX_FLAG, RX_BYTE_NUMBER, RX_DONE, RX_CRC_ERR, RX_ABORT
    );
endinterface

// File: rtl/mod_hi_speed_protocol_decoder.sv
// Parses MARKER, FLAG, LEN_H, LEN_L, DATA[LEN], CRC_H, CRC_L frames, writes DATA to the RX RAM
// and checks CRC-16 (poly 0x1021, init 0x0000, MSB first) over MARKER..DATA.
module mod_hi_speed_protocol_decoder #(
    parameter int         QUARTZ      = 24,
    parameter logic [7:0] MARKER_BYTE = 8'hB6,
    parameter int         TIMEOUT_US  = 200,
    parameter int         MAX_BYTES   = 4096
) (
    input logic                            CLK,
    input logic                            RESET,
    mod_hi_speed_protocol_decoder_if.slave bus
);
    localparam int          TMO_LIMIT = QUARTZ * TIMEOUT_US;
    localparam int          TMO_W     = $clog2(TMO_LIMIT + 1);
    localparam logic [15:0] MAX_LEN   = 16'(MAX_BYTES);

    typedef enum logic [3:0] {
        S_IDLE, S_FLAG, S_LEN_H, S_LEN_L, S_DATA, S_WR, S_CRC_H, S_CRC_L, S_CHECK
    } state_t;

    state_t           state;
    logic [7:0]       len_h;
    logic [7:0]       rx_crc_h;
    logic [15:0]      len;
    logic [15:0]      crc_calc;
    logic [TMO_W-1:0] tmo_cnt;

    logic        accept;
    logic        byte_ok;
    logic        marker_ok;
    logic        crc_feed;
    logic        tmo_hit;
    logic        abort_now;
    logic [15:0] len_rx;

    function automatic logic [15:0] crc16_upd(input logic [15:0] crc_in, input logic [7:0] data);
        logic [15:0] c;
        c = crc_in ^ {data, 8'h00};
        for (int i = 0; i < 8; i++)
            c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
        return c;
    endfunction

    // RX_STR has no meaning while a RAM write is pending or during the one-cycle CHECK.
    assign accept    = bus.RX_STR && (state != S_WR) && (state != S_CHECK);
    assign byte_ok   = accept && !bus.RX_ERR;
    assign marker_ok = (state == S_IDLE) && bus.RX_STR && !bus.RX_ERR
                       && (bus.RX_DATA == MARKER_BYTE);
    assign crc_feed  = accept && (state inside {S_FLAG, S_LEN_H, S_LEN_L, S_DATA});
    assign len_rx    = {len_h, bus.RX_DATA};
    assign tmo_hit   = bus.DECODING && (state != S_WR) && (tmo_cnt == TMO_W'(TMO_LIMIT - 1));

    assign abort_now = (state != S_IDLE) && (
                           (accept && bus.RX_ERR)
                        || ((state == S_WR) && bus.RX_STR)
                        || ((state == S_LEN_L) && byte_ok && (len_rx > MAX_LEN))
                        || (tmo_hit && !accept));

    // A marker in the first IDLE cycle after a frame starts from zero, not from the stale CRC.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            crc_calc <= '0;
        else if (state == S_IDLE)
            crc_calc <= marker_ok ? crc16_upd(16'h0000, bus.RX_DATA) : 16'h0000;
        else if (crc_feed)
            crc_calc <= crc16_upd(crc_calc, bus.RX_DATA);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state               <= S_IDLE;
            len_h               <= '0;
            len                 <= '0;
            rx_crc_h            <= '0;
            tmo_cnt             <= '0;
            bus.RX_RAM_REQ_WR   <= 1'b0;
            bus.RX_RAM_ADDR_OUT <= '0;
            bus.RX_RAM_DATA_OUT <= '0;
            bus.DECODING        <= 1'b0;
            bus.RX_FLAG         <= '0;
            bus.RX_BYTE_NUMBER  <= '0;
            bus.RX_DONE         <= 1'b0;
            bus.RX_CRC_ERR      <= 1'b0;
            bus.RX_ABORT        <= 1'b0;
        end else begin
            bus.RX_DONE  <= 1'b0;
            bus.RX_ABORT <= 1'b0;

            if ((state == S_IDLE) || accept)
                tmo_cnt <= '0;
            else if (bus.DECODING && (state != S_WR))
                tmo_cnt <= tmo_cnt + TMO_W'(1);

            // The header length is reported even when it is too large and the frame is dropped.
            if (byte_ok && (state == S_LEN_L))
                bus.RX_BYTE_NUMBER <= len_rx;

            if (abort_now) begin
                bus.RX_ABORT        <= 1'b1;
                bus.RX_RAM_REQ_WR   <= 1'b0;
                bus.DECODING        <= 1'b0;
                bus.RX_RAM_ADDR_OUT <= '0;
                state               <= S_IDLE;
            end else begin
                unique case (state)
                    S_IDLE: if (marker_ok) begin
                        bus.DECODING <= 1'b1;
                        state        <= S_FLAG;
                    end
                    S_FLAG: if (byte_ok) begin
                        bus.RX_FLAG <= bus.RX_DATA;
                        state       <= S_LEN_H;
                    end
                    S_LEN_H: if (byte_ok) begin
                        len_h <= bus.RX_DATA;
                        state <= S_LEN_L;
                    end
                    S_LEN_L: if (byte_ok) begin
                        len                 <= len_rx;
                        bus.RX_RAM_ADDR_OUT <= '0;
                        state               <= (len_rx == 16'd0) ? S_CRC_H : S_DATA;
                    end
                    S_DATA: if (byte_ok) begin
                        bus.RX_RAM_DATA_OUT <= bus.RX_DATA;
                        bus.RX_RAM_REQ_WR   <= 1'b1;
                        state               <= S_WR;
                    end
                    S_WR: if (bus.RX_RAM_RDY_WR) begin
                        bus.RX_RAM_REQ_WR   <= 1'b0;
                        bus.RX_RAM_ADDR_OUT <= bus.RX_RAM_ADDR_OUT + 16'd1;
                        state <= ((bus.RX_RAM_ADDR_OUT + 16'd1) == len) ? S_CRC_H : S_DATA;
                    end
                    S_CRC_H: if (byte_ok) begin
                        rx_crc_h <= bus.RX_DATA;
                        state    <= S_CRC_L;
                    end
                    S_CRC_L: if (byte_ok) begin
                        bus.RX_DONE    <= 1'b1;
                        bus.RX_CRC_ERR <= ({rx_crc_h, bus.RX_DATA} != crc_calc);
                        state          <= S_CHECK;
                    end
                    S_CHECK: begin
                        bus.DECODING <= 1'b0;
                        state        <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mod_hi_speed_protocol_decoder.sv
// Scoreboard bench for mod_hi_speed_protocol_decoder: expected RAM writes and frame events are
// queued as bytes are driven and compared when the decoder writes RAM or pulses DONE/ABORT.
`timescale 1ns/1ps
module tb_mod_hi_speed_protocol_decoder;
    localparam int TMO_CYC = 24 * 200;
    localparam int GAP     = 6;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        bit          is_abort;
        bit          crc_err;
        logic [7:0]  flag;
        logic [15:0] len;
    } ev_t;
    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic CLK   = 1'b0;
    logic RESET = 1'b1;

    mod_hi_speed_protocol_decoder_if bus ();

    mod_hi_speed_protocol_decoder dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    ev_t         ev_q[$];
    wr_t         wr_q[$];
    int          n_checks  = 0;
    int          n_pass    = 0;
    bit          rdy_en    = 1'b1;
    logic [7:0]  last_flag = 8'h00;
    logic [15:0] last_len  = 16'h0000;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Bit-serial reference CRC-16, poly 0x1021, init 0, MSB first.
    function automatic logic [15:0] crc_model(input bq_t bytes);
        logic [15:0] c;
        logic        fb;
        c = 16'h0000;
        foreach (bytes[i]) begin
            for (int b = 7; b >= 0; b--) begin
                fb = c[15] ^ bytes[i][b];
                c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
            end
        end
        return c;
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit err = 1'b0);
        @(negedge CLK);
        bus.RX_DATA = b;
        bus.RX_STR  = 1'b1;
        bus.RX_ERR  = err;
        @(negedge CLK);
        bus.RX_STR  = 1'b0;
        bus.RX_ERR  = 1'b0;
        repeat (GAP) @(negedge CLK);
    endtask

    task automatic expect_abort();
        ev_t ev;
        ev.is_abort = 1'b1;
        ev.crc_err  = 1'b0;
        ev.flag     = last_flag;
        ev.len      = last_len;
        ev_q.push_back(ev);
    endtask

    task automatic send_frame(input logic [7:0] flag, input bq_t data, input logic [15:0] crc_xor);
        bq_t         fr;
        logic [15:0] len;
        logic [15:0] crc;
        ev_t         ev;
        wr_t         wr;
        len = 16'(data.size());
        fr.push_back(8'hB6);
        fr.push_back(flag);
        fr.push_back(len[15:8]);
        fr.push_back(len[7:0]);
        foreach (data[i]) begin
            fr.push_back(data[i]);
            wr.addr = 16'(i);
            wr.data = data[i];
            wr_q.push_back(wr);
        end
        crc         = crc_model(fr) ^ crc_xor;
        last_flag   = flag;
        last_len    = len;
        ev.is_abort = 1'b0;
        ev.crc_err  = (crc_xor != 16'h0000);
        ev.flag     = flag;
        ev.len      = len;
        ev_q.push_back(ev);
        foreach (fr[i]) send_byte(fr[i]);
        send_byte(crc[15:8]);
        send_byte(crc[7:0]);
    endtask

    task automatic wait_events();
        int n;
        n = 0;
        while ((ev_q.size() != 0 || wr_q.size() != 0) && n < 200) begin
            @(negedge CLK);
            n++;
        end
        check("ev_drained", 32'(ev_q.size()), 32'd0);
        check("wr_drained", 32'(wr_q.size()), 32'd0);
        repeat (2) @(negedge CLK);
    endtask

    // RAM model: acknowledges each write request with a one-cycle RDY two clocks after REQ.
    initial begin : ram_responder
        wr_t exp;
        bus.RX_RAM_RDY_WR = 1'b0;
        forever begin
            @(negedge CLK);
            if (!RESET && rdy_en && bus.RX_RAM_REQ_WR) begin
                check("wr_expected", 32'(wr_q.size() != 0), 32'd1);
                if (wr_q.size() != 0) begin
                    exp = wr_q.pop_front();
                    check("wr_addr", 32'(bus.RX_RAM_ADDR_OUT), 32'(exp.addr));
                    check("wr_data", 32'(bus.RX_RAM_DATA_OUT), 32'(exp.data));
                end
                @(negedge CLK);
                bus.RX_RAM_RDY_WR = 1'b1;
                @(negedge CLK);
                bus.RX_RAM_RDY_WR = 1'b0;
            end
        end
    end

    initial begin : event_monitor
        bit  prev_done;
        ev_t exp;
        prev_done = 1'b0;
        forever begin
            @(negedge CLK);
            if (!RESET && (bus.RX_DONE || bus.RX_ABORT)) begin
                check("done_abort_excl", 32'(bus.RX_DONE & bus.RX_ABORT), 32'd0);
                check("ev_expected", 32'(ev_q.size() != 0), 32'd1);
                if (ev_q.size() != 0) begin
                    exp = ev_q.pop_front();
                    check("ev_abort", 32'(bus.RX_ABORT), 32'(exp.is_abort));
                    if (!exp.is_abort) begin
                        check("crc_err", 32'(bus.RX_CRC_ERR), 32'(exp.crc_err));
                        check("done_single", 32'(prev_done), 32'd0);
                    end
                    check("rx_flag", 32'(bus.RX_FLAG), 32'(exp.flag));
                    check("rx_byte_number", 32'(bus.RX_BYTE_NUMBER), 32'(exp.len));
                end
            end
            prev_done = bus.RX_DONE;
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check_outputs_zero(input string tag);
        check({tag, "_req"},   32'(bus.RX_RAM_REQ_WR),   32'd0);
        check({tag, "_addr"},  32'(bus.RX_RAM_ADDR_OUT), 32'd0);
        check({tag, "_data"},  32'(bus.RX_RAM_DATA_OUT), 32'd0);
        check({tag, "_dec"},   32'(bus.DECODING),        32'd0);
        check({tag, "_flag"},  32'(bus.RX_FLAG),         32'd0);
        check({tag, "_len"},   32'(bus.RX_BYTE_NUMBER),  32'd0);
        check({tag, "_done"},  32'(bus.RX_DONE),         32'd0);
        check({tag, "_crce"},  32'(bus.RX_CRC_ERR),      32'd0);
        check({tag, "_abort"}, 32'(bus.RX_ABORT),        32'd0);
    endtask

    initial begin : stimulus
        bq_t d;
        int  cyc;
        bit  seen;
        wr_t wr;

        bus.RX_DATA = 8'h00;
        bus.RX_STR  = 1'b0;
        bus.RX_ERR  = 1'b0;
        RESET       = 1'b1;
        repeat (3) @(negedge CLK);
        check_outputs_zero("reset");
        RESET = 1'b0;
        repeat (2) @(negedge CLK);

        // Basic frame, good CRC.
        d = '{8'h11, 8'h22, 8'h33};
        send_frame(8'h05, d, 16'h0000);
        wait_events();
        check("t1_decoding_low", 32'(bus.DECODING), 32'd0);

        // Corrupted CRC_L.
        send_frame(8'h05, d, 16'h0001);
        wait_events();

        // Junk before the marker, then an empty frame.
        send_byte(8'h00);
        send_byte(8'hFF);
        check("t3_idle_after_junk", 32'(bus.DECODING), 32'd0);
        d.delete();
        send_frame(8'h7A, d, 16'h0000);
        wait_events();

        // Inter-byte timeout inside the data field.
        wr.addr = 16'h0000;
        wr.data = 8'hAA;
        wr_q.push_back(wr);
        last_flag = 8'h01;
        last_len  = 16'h0002;
        expect_abort();
        send_byte(8'hB6);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'hAA);
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < 25 * 250 - GAP) begin
            @(negedge CLK);
            cyc++;
            if (bus.RX_ABORT) seen = 1'b1;
        end
        check("t4_abort_seen", 32'(seen), 32'd1);
        check("t4_abort_not_early", 32'(cyc >= TMO_CYC - 60), 32'd1);
        check("t4_abort_within_limit", 32'(cyc <= TMO_CYC), 32'd1);
        check("t4_req_low", 32'(bus.RX_RAM_REQ_WR), 32'd0);
        wait_events();
        d = '{8'hC1, 8'hC2};
        send_frame(8'h02, d, 16'h0000);
        wait_events();

        // Oversized LEN aborts on LEN_L; RX_BYTE_NUMBER still takes the header value.
        last_flag = 8'h03;
        last_len  = 16'h1001;
        expect_abort();
        send_byte(8'hB6);
        send_byte(8'h03);
        send_byte(8'h10);
        send_byte(8'h01);
        wait_events();
        check("t5_dec_low", 32'(bus.DECODING), 32'd0);

        // Byte error on FLAG aborts; header outputs keep their previous values.
        expect_abort();
        send_byte(8'hB6);
        send_byte(8'h44, 1'b1);
        wait_events();

        // A byte arriving while the RAM write is still pending is an overrun.
        rdy_en    = 1'b0;
        last_flag = 8'h09;
        last_len  = 16'h0002;
        expect_abort();
        send_byte(8'hB6);
        send_byte(8'h09);
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'hAA);
        check("ovr_req_pending", 32'(bus.RX_RAM_REQ_WR), 32'd1);
        send_byte(8'hBB);
        wait_events();
        check("ovr_req_low", 32'(bus.RX_RAM_REQ_WR), 32'd0);
        rdy_en = 1'b1;

        // RESET while a RAM request is pending.
        rdy_en = 1'b0;
        send_byte(8'hB6);
        send_byte(8'h05);
        send_byte(8'h00);
        send_byte(8'h03);
        send_byte(8'h11);
        check("t6_req_before_reset", 32'(bus.RX_RAM_REQ_WR), 32'd1);
        check("t6_dec_before_reset", 32'(bus.DECODING), 32'd1);
        #2;
        RESET = 1'b1;
        #1;
        check_outputs_zero("t6_async");
        repeat (2) @(negedge CLK);
        RESET     = 1'b0;
        rdy_en    = 1'b1;
        last_flag = 8'h00;
        last_len  = 16'h0000;
        @(negedge CLK);
        d = '{8'h11, 8'h22, 8'h33};
        send_frame(8'h05, d, 16'h0000);
        wait_events();
        check("t6_decoding_low", 32'(bus.DECODING), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
